cpu_switch_ctrl: RTL

Sequenced A/B CPU switch controller for the dual-CPU switch box. It replaces the combinational switch decision with a registered state machine. It filters the io_a/io_b health lines, counts error events, and computes a target CPU. It then changes the switch output only at a UART frame gap on the currently forwarded CPU line, or after a bounded wait. A minimum dwell time after each switch prevents ping-pong.

---
 rtl/cpu_switch_if.sv | 24 ++
 rtl/cpu_switch_ctrl.sv | 107 ++++++++++
 2 files changed

// File: rtl/cpu_switch_if.sv
// cpu_switch_if: health, command, serial-line and switch-status signals of the dual-CPU switch box
interface cpu_switch_if #(
  parameter int CNT_W = 8
);
  logic io_a;
  logic io_b;
  logic force_swi;
  logic com_swi;
  logic srx_cpuA;
  logic srx_cpuB;
  logic switch;
  logic pending;
  logic swi_evt;
  logic [CNT_W-1:0] a_err_num;
  logic [CNT_W-1:0] b_err_num;
  modport master(
    output io_a, io_b, force_swi, com_swi, srx_cpuA, srx_cpuB,
    input switch, pending, swi_evt, a_err_num, b_err_num
  );
  modport slave(
    input io_a, io_b, force_swi, com_swi, srx_cpuA, srx_cpuB,
    output switch, pending, swi_evt, a_err_num, b_err_num
  );
endinterface

// File: rtl/cpu_switch_ctrl.sv
// cpu_switch_ctrl: filtered-health A/B CPU selector that only switches at a frame gap or after a bounded wait
module cpu_switch_ctrl #(
  parameter int FILT_LEN = 16,
  parameter int IDLE_T   = 1600,
  parameter int MAX_WAIT = 65536,
  parameter int DWELL_T  = 4096,
  parameter int CNT_W    = 8
) (
  input logic clk,
  input logic rst_n,
  cpu_switch_if.slave bus
);
  localparam int FW = $clog2(FILT_LEN);
  localparam int IW = $clog2(IDLE_T + 1);
  localparam int WW = $clog2(MAX_WAIT);
  localparam int DW = $clog2(DWELL_T + 1);
  localparam logic [CNT_W-1:0] CMAX = '1;
  typedef enum logic [1:0] {RUN_A, WAIT_B, RUN_B, WAIT_A} state_t;
  logic [1:0] ia_q, ia_d, ib_q, ib_d, ra_q, ra_d, rb_q, rb_d;
  logic fa_q, fa_d, fb_q, fb_d;
  logic [FW-1:0] ca_q, ca_d, cb_q, cb_d;
  logic [CNT_W-1:0] an_q, an_d, bn_q, bn_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic switch_q, switch_d, evt_q, evt_d;
  state_t state_q, state_d;
  logic a_err, b_err, a_rise, b_rise, sat, tgt, line, go;
  // synchronizers, glitch filters, error counters, target selection and switch sequencing
  always_comb begin
    ia_d = {ia_q[0], bus.io_a};
    ib_d = {ib_q[0], bus.io_b};
    ra_d = {ra_q[0], bus.srx_cpuA};
    rb_d = {rb_q[0], bus.srx_cpuB};
    a_err = ~ia_q[1];
    b_err = ~ib_q[1];
    a_rise = a_err & ~fa_q & (ca_q == FW'(FILT_LEN - 1));
    b_rise = b_err & ~fb_q & (cb_q == FW'(FILT_LEN - 1));
    fa_d = fa_q;
    ca_d = '0;
    if (a_err != fa_q) {fa_d, ca_d} = (ca_q == FW'(FILT_LEN - 1)) ? {a_err, FW'(0)} : {fa_q, ca_q + FW'(1)};
    fb_d = fb_q;
    cb_d = '0;
    if (b_err != fb_q) {fb_d, cb_d} = (cb_q == FW'(FILT_LEN - 1)) ? {b_err, FW'(0)} : {fb_q, cb_q + FW'(1)};
    sat = (an_q == CMAX) || (bn_q == CMAX);
    an_d = bus.force_swi ? '0 : sat ? CNT_W'(an_q > bn_q) : an_q + CNT_W'(a_rise);
    bn_d = bus.force_swi ? '0 : sat ? CNT_W'(an_q <= bn_q) : bn_q + CNT_W'(b_rise);
    tgt = (fa_q ^ fb_q) ? fa_q : (fa_q | bus.force_swi) ? bus.com_swi : (an_q != bn_q) ? (an_q > bn_q) : switch_q;
    line = switch_q ? rb_q[1] : ra_q[1];
    go = (idle_q == IW'(IDLE_T)) || (wcnt_q == WW'(MAX_WAIT - 1));
    unique case (state_q)
      RUN_A:   state_d = (tgt && (dwell_q == '0 || bus.force_swi)) ? WAIT_B : RUN_A;
      RUN_B:   state_d = (!tgt && (dwell_q == '0 || bus.force_swi)) ? WAIT_A : RUN_B;
      WAIT_B:  state_d = !tgt ? RUN_A : go ? RUN_B : WAIT_B;
      WAIT_A:  state_d = tgt ? RUN_B : go ? RUN_A : WAIT_A;
      default: state_d = RUN_A;
    endcase
    evt_d = (state_q == WAIT_B && state_d == RUN_B) || (state_q == WAIT_A && state_d == RUN_A);
    switch_d = switch_q ^ evt_d;
    wcnt_d = (state_q == RUN_A || state_q == RUN_B) ? '0 : wcnt_q + WW'(1);
    idle_d = (evt_d || !line) ? '0 : (idle_q == IW'(IDLE_T)) ? idle_q : idle_q + IW'(1);
    dwell_d = evt_d ? DW'(DWELL_T) : (dwell_q != '0) ? dwell_q - DW'(1) : '0;
  end
  // state register; synchronizers preset to healthy/idle on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ia_q <= 2'b11;
      ib_q <= 2'b11;
      ra_q <= 2'b11;
      rb_q <= 2'b11;
      fa_q <= 1'b0;
      fb_q <= 1'b0;
      ca_q <= '0;
      cb_q <= '0;
      an_q <= '0;
      bn_q <= '0;
      idle_q <= '0;
      wcnt_q <= '0;
      dwell_q <= '0;
      switch_q <= 1'b0;
      evt_q <= 1'b0;
      state_q <= RUN_A;
    end else begin
      ia_q <= ia_d;
      ib_q <= ib_d;
      ra_q <= ra_d;
      rb_q <= rb_d;
      fa_q <= fa_d;
      fb_q <= fb_d;
      ca_q <= ca_d;
      cb_q <= cb_d;
      an_q <= an_d;
      bn_q <= bn_d;
      idle_q <= idle_d;
      wcnt_q <= wcnt_d;
      dwell_q <= dwell_d;
      switch_q <= switch_d;
      evt_q <= evt_d;
      state_q <= state_d;
    end
  end
  assign bus.switch = switch_q;
  assign bus.swi_evt = evt_q;
  assign bus.pending = (state_q == WAIT_A) || (state_q == WAIT_B);
  assign bus.a_err_num = an_q;
  assign bus.b_err_num = bn_q;
endmodule
